ex_operand_stage: RTL and testbench

ID/EX pipeline register and operand-select stage of the five-stage MIPS core. It sits directly upstream of the ALU. Each cycle it latches one decoded instruction from ID. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, or by inserting bubbles. It presents the ALU with its 4-bit `ctrl`, `x` and `y` operands, plus the store data and writeback tags that travel on to EX/MEM.

---
 rtl/ex_operand_stage.sv | 144 ++++++++++++++
 tb/tb_ex_operand_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register plus operand select and RAW hazard detection ahead of the ALU; EX_FORWARDING_EN enables the bypass muxes.
// Latency: one cycle ID->EX; ALU operands leave the bypass muxes in the same cycle as ex_valid.
// Backpressure: hold freezes every stage register; stall (combinational) asks IF/ID to hold while a bubble enters EX.
module ex_operand_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [3:0]    id_alu_ctrl,
    input  logic [RW-1:0] id_rs_addr,
    input  logic [RW-1:0] id_rt_addr,
    input  logic [RW-1:0] id_rd_addr,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic          id_use_imm,
    input  logic          id_use_shamt,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic          stall,
    output logic          ex_valid,
    output logic [3:0]    ex_alu_ctrl,
    output logic [DW-1:0] ex_x,
    output logic [DW-1:0] ex_y,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_rd,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write
);

    typedef struct packed {
        logic          valid;
        logic [3:0]    alu_ctrl;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [4:0]    shamt;
        logic          use_imm;
        logic          use_shamt;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
    } stage_t;

    stage_t        id_d;
    stage_t        ex_q;
    logic          hazard;
    logic [DW-1:0] rs_fwd;
    logic [DW-1:0] rt_fwd;

    always_comb begin
        id_d           = '0;
        id_d.valid     = id_valid;
        id_d.alu_ctrl  = id_alu_ctrl;
        id_d.rs        = id_rs_addr;
        id_d.rt        = id_rt_addr;
        id_d.rd        = id_rd_addr;
        id_d.rs_data   = id_rs_data;
        id_d.rt_data   = id_rt_data;
        id_d.imm       = id_imm;
        id_d.shamt     = id_shamt;
        id_d.use_imm   = id_use_imm;
        id_d.use_shamt = id_use_shamt;
        id_d.reg_write = id_reg_write;
        id_d.mem_read  = id_mem_read;
        id_d.mem_write = id_mem_write;
    end

    // Bubbles clear data fields too, so EX never sees stale operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else if (!hold) begin
            if (flush || stall) begin
                ex_q <= '0;
            end else begin
                ex_q <= id_d;
            end
        end
    end

    function automatic logic src_hit(input logic [RW-1:0] r);
        return (r != '0) && ((r == id_rs_addr) || (r == id_rt_addr));
    endfunction

`ifdef EX_FORWARDING_EN
    // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
    function automatic logic [DW-1:0] fwd(input logic [RW-1:0] r, input logic [DW-1:0] d);
        if ((r != '0) && exmem_reg_write && (exmem_rd == r)) begin
            return exmem_result;
        end else if ((r != '0) && memwb_reg_write && (memwb_rd == r)) begin
            return memwb_result;
        end
        return d;
    endfunction

    always_comb begin
        rs_fwd = fwd(ex_q.rs, ex_q.rs_data);
        rt_fwd = fwd(ex_q.rt, ex_q.rt_data);
        hazard = ex_q.valid & ex_q.mem_read & src_hit(ex_q.rd);
    end
`else
    logic unused_nofwd;
    assign unused_nofwd = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result, ex_q.rs, ex_q.rt};

    // Without bypass, wait until the producer has left EX/MEM; the write-first register file covers WB.
    always_comb begin
        rs_fwd = ex_q.rs_data;
        rt_fwd = ex_q.rt_data;
        hazard = (ex_q.valid & ex_q.mem_read & src_hit(ex_q.rd))
               | (ex_q.valid & ex_q.reg_write & src_hit(ex_q.rd))
               | (exmem_reg_write & src_hit(exmem_rd));
    end
`endif

    assign stall         = id_valid & ~flush & hazard;
    assign ex_valid      = ex_q.valid;
    assign ex_alu_ctrl   = ex_q.alu_ctrl;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
    assign ex_mem_read   = ex_q.valid & ex_q.mem_read;
    assign ex_mem_write  = ex_q.valid & ex_q.mem_write;
    // The ALU shifts y by x, so the shift amount rides on x.
    assign ex_x          = ex_q.use_shamt ? {{(DW-5){1'b0}}, ex_q.shamt} : rs_fwd;
    assign ex_y          = ex_q.use_imm ? ex_q.imm : rt_fwd;
    assign ex_store_data = rt_fwd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed-vector bench for ex_operand_stage; expectations follow whether EX_FORWARDING_EN is defined.
module tb_ex_operand_stage;

    typedef logic [31:0] word_t;

    // Inputs applied for one cycle, stall expected before the edge, ex_* expected after it.
    typedef struct {
        word_t rst, hold, flush, vld, ctrl, rs, rt, rd, rs_d, rt_d, imm, shamt;
        word_t ui, us, rw, mr, mw, exw, exrd, exres, mww, mwrd, mwres;
        word_t e_stall, e_valid, e_ctrl, e_x, e_y, e_sd, e_rd, e_rw, e_mr, e_mw;
    } vec_t;

`ifdef EX_FORWARDING_EN
    localparam word_t LU_X = 32'h0000_CAFE;
`else
    localparam word_t LU_X = 32'h0000_DEAD;
`endif

    logic        clk;
    logic        rst, hold, flush, id_valid;
    logic [3:0]  id_alu_ctrl;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_use_imm, id_use_shamt, id_reg_write, id_mem_read, id_mem_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [3:0]  ex_alu_ctrl;
    logic [31:0] ex_x, ex_y, ex_store_data;
    logic [4:0]  ex_rd;

    int total;
    int passed;

    ex_operand_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_alu_ctrl(id_alu_ctrl), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rd_addr(id_rd_addr), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_use_imm(id_use_imm),
        .id_use_shamt(id_use_shamt), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .stall(stall), .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl), .ex_x(ex_x),
        .ex_y(ex_y), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input word_t act, input word_t exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string tag, input int idx);
        string n;
        n = $sformatf("%s[%0d]", tag, idx);
        rst = v.rst[0]; hold = v.hold[0]; flush = v.flush[0]; id_valid = v.vld[0];
        id_alu_ctrl = v.ctrl[3:0]; id_rs_addr = v.rs[4:0]; id_rt_addr = v.rt[4:0];
        id_rd_addr = v.rd[4:0]; id_rs_data = v.rs_d; id_rt_data = v.rt_d; id_imm = v.imm;
        id_shamt = v.shamt[4:0]; id_use_imm = v.ui[0]; id_use_shamt = v.us[0];
        id_reg_write = v.rw[0]; id_mem_read = v.mr[0]; id_mem_write = v.mw[0];
        exmem_reg_write = v.exw[0]; exmem_rd = v.exrd[4:0]; exmem_result = v.exres;
        memwb_reg_write = v.mww[0]; memwb_rd = v.mwrd[4:0]; memwb_result = v.mwres;
        #1;
        chk({n, ".stall"}, 32'(stall), v.e_stall);
        @(posedge clk);
        #1;
        chk({n, ".valid"}, 32'(ex_valid), v.e_valid);
        chk({n, ".ctrl"}, 32'(ex_alu_ctrl), v.e_ctrl);
        chk({n, ".x"}, ex_x, v.e_x);
        chk({n, ".y"}, ex_y, v.e_y);
        chk({n, ".store"}, ex_store_data, v.e_sd);
        chk({n, ".rd"}, 32'(ex_rd), v.e_rd);
        chk({n, ".reg_write"}, 32'(ex_reg_write), v.e_rw);
        chk({n, ".mem_read"}, 32'(ex_mem_read), v.e_mr);
        chk({n, ".mem_write"}, 32'(ex_mem_write), v.e_mw);
    endtask

    vec_t main_tbl [15];
    vec_t lu_tbl   [4];
`ifdef EX_FORWARDING_EN
    vec_t raw_tbl  [5];
`else
    vec_t raw_tbl  [4];
`endif

    initial begin
        total = 0;
        passed = 0;
        //              rst hld fl vld ctl rs rt rd rs_d     rt_d    imm    sh ui us rw mr mw exw exrd exres    mww mwrd mwres     st val ctl x        y       sd      rd rw mr mw
        main_tbl[0]  = '{1, 0, 0, 1, 0, 1, 2, 3, 'h11,    'h22,   0,     0, 0, 0, 1, 0, 0, 0, 0,  0,       0, 0,  0,        0, 0, 0, 0,       0,      0,      0, 0, 0, 0};
        main_tbl[1]  = '{0, 0, 0, 1, 0, 1, 2, 3, 5,       2,      0,     0, 0, 0, 1, 0, 0, 0, 0,  0,       0, 0,  0,        0, 1, 0, 5,       2,      2,      3, 1, 0, 0};
        main_tbl[2]  = '{0, 0, 0, 1, 0, 4, 6, 6, 'h100,   'h55,   'h10,  0, 1, 0, 1, 0, 0, 1, 9,  'hAAAA,  1, 10, 'hBBBB,   0, 1, 0, 'h100,   'h10,   'h55,   6, 1, 0, 0};
        main_tbl[3]  = '{0, 0, 1, 1, 0, 1, 2, 0, 5,       6,      8,     0, 1, 0, 0, 0, 1, 0, 0,  0,       0, 0,  0,        0, 0, 0, 0,       0,      0,      0, 0, 0, 0};
        main_tbl[4]  = '{0, 0, 0, 1, 0, 1, 8, 8, 'h1000,  'h77,   4,     0, 1, 0, 1, 1, 0, 0, 0,  0,       0, 0,  0,        0, 1, 0, 'h1000,  4,      'h77,   8, 1, 1, 0};
        main_tbl[5]  = '{0, 1, 0, 1, 0, 8, 1, 9, 'hDEAD,  3,      0,     0, 0, 0, 1, 0, 0, 0, 0,  0,       0, 0,  0,        1, 1, 0, 'h1000,  4,      'h77,   8, 1, 1, 0};
        main_tbl[6]  = '{0, 0, 0, 1, 0, 8, 1, 9, 'hDEAD,  3,      0,     0, 0, 0, 1, 0, 0, 0, 0,  0,       0, 0,  0,        1, 0, 0, 0,       0,      0,      0, 0, 0, 0};
        main_tbl[7]  = '{0, 0, 0, 1, 0, 8, 1, 9, 'hDEAD,  3,      0,     0, 0, 0, 1, 0, 0, 0, 0,  0,       1, 8,  'hCAFE,   0, 1, 0, LU_X,    3,      3,      9, 1, 0, 0};
        main_tbl[8]  = '{0, 0, 0, 1, 7, 0, 7, 2, 'h99,    1,      0,     4, 0, 1, 1, 0, 0, 0, 0,  0,       0, 0,  0,        0, 1, 7, 4,       1,      1,      2, 1, 0, 0};
        main_tbl[9]  = '{0, 1, 0, 1, 9, 3, 4, 5, 'h31,    'h41,   'h51,  9, 1, 0, 1, 1, 1, 0, 0,  0,       0, 0,  0,        0, 1, 7, 4,       1,      1,      2, 1, 0, 0};
        main_tbl[10] = '{0, 1, 0, 1, 3, 4, 3, 6, 'h32,    'h42,   'h52,  1, 0, 0, 0, 0, 1, 0, 0,  0,       1, 9,  'h5,      0, 1, 7, 4,       1,      1,      2, 1, 0, 0};
        main_tbl[11] = '{0, 1, 0, 0, 5, 5, 6, 7, 'h33,    'h43,   'h53,  2, 0, 1, 1, 0, 0, 0, 0,  0,       0, 0,  0,        0, 1, 7, 4,       1,      1,      2, 1, 0, 0};
        main_tbl[12] = '{1, 0, 0, 1, 2, 5, 6, 7, 'h44,    'h45,   0,     0, 0, 0, 1, 0, 0, 0, 0,  0,       0, 0,  0,        0, 0, 0, 0,       0,      0,      0, 0, 0, 0};
        main_tbl[13] = '{0, 0, 0, 0, 9, 3, 4, 7, 'h123,   'h456,  0,     0, 0, 0, 1, 1, 1, 0, 0,  0,       0, 0,  0,        0, 0, 9, 'h123,   'h456,  'h456,  7, 0, 0, 0};
        main_tbl[14] = '{0, 0, 0, 1, 1, 7, 6, 0, 'h70,    'h60,   8,     0, 1, 0, 0, 0, 1, 0, 0,  0,       0, 0,  0,        0, 1, 1, 'h70,    8,      'h60,   0, 0, 0, 1};

        lu_tbl[0]    = '{0, 0, 0, 1, 0, 1, 8, 8, 'h200,   0,      4,     0, 1, 0, 1, 1, 0, 0, 0,  0,       0, 0,  0,        0, 1, 0, 'h200,   4,      0,      8, 1, 1, 0};
        lu_tbl[1]    = '{0, 0, 1, 1, 0, 8, 1, 9, 'hDEAD,  3,      0,     0, 0, 0, 1, 0, 0, 0, 0,  0,       0, 0,  0,        0, 0, 0, 0,       0,      0,      0, 0, 0, 0};
        lu_tbl[2]    = '{0, 0, 0, 1, 0, 1, 8, 8, 'h200,   0,      4,     0, 1, 0, 1, 1, 0, 0, 0,  0,       0, 0,  0,        0, 1, 0, 'h200,   4,      0,      8, 1, 1, 0};
        lu_tbl[3]    = '{1, 0, 0, 1, 0, 8, 1, 9, 'hDEAD,  3,      0,     0, 0, 0, 1, 0, 0, 0, 0,  0,       0, 0,  0,        1, 0, 0, 0,       0,      0,      0, 0, 0, 0};

`ifdef EX_FORWARDING_EN
        raw_tbl[0]   = '{0, 0, 0, 1, 0, 1, 2, 3, 1,       6,      0,     0, 0, 0, 1, 0, 0, 0, 0,  0,       0, 0,  0,        0, 1, 0, 1,       6,      6,      3, 1, 0, 0};
        raw_tbl[1]   = '{0, 0, 0, 1, 1, 3, 1, 4, 'hDEAD,  1,      0,     0, 0, 0, 1, 0, 0, 1, 3,  7,       0, 0,  0,        0, 1, 1, 7,       1,      1,      4, 1, 0, 0};
        raw_tbl[2]   = '{0, 0, 0, 1, 0, 5, 5, 6, 'h55,    'h66,   0,     0, 0, 0, 1, 0, 0, 1, 5,  'h11,    1, 5,  'h22,     0, 1, 0, 'h11,    'h11,   'h11,   6, 1, 0, 0};
        raw_tbl[3]   = '{0, 0, 0, 1, 0, 0, 5, 6, 'h33,    'h66,   0,     0, 0, 0, 1, 0, 0, 1, 0,  'h11,    1, 6,  'h22,     0, 1, 0, 'h33,    'h66,   'h66,   6, 1, 0, 0};
        raw_tbl[4]   = '{0, 0, 0, 1, 0, 5, 2, 6, 'h55,    2,      0,     0, 0, 0, 1, 0, 0, 1, 6,  'h11,    1, 5,  'h22,     0, 1, 0, 'h22,    2,      2,      6, 1, 0, 0};
`else
        raw_tbl[0]   = '{0, 0, 0, 1, 0, 1, 2, 3, 1,       6,      0,     0, 0, 0, 1, 0, 0, 0, 0,  0,       0, 0,  0,        0, 1, 0, 1,       6,      6,      3, 1, 0, 0};
        raw_tbl[1]   = '{0, 0, 0, 1, 1, 3, 1, 4, 'hDEAD,  1,      0,     0, 0, 0, 1, 0, 0, 0, 0,  0,       0, 0,  0,        1, 0, 0, 0,       0,      0,      0, 0, 0, 0};
        raw_tbl[2]   = '{0, 0, 0, 1, 1, 3, 1, 4, 'hDEAD,  1,      0,     0, 0, 0, 1, 0, 0, 1, 3,  7,       0, 0,  0,        1, 0, 0, 0,       0,      0,      0, 0, 0, 0};
        raw_tbl[3]   = '{0, 0, 0, 1, 1, 3, 1, 4, 7,       1,      0,     0, 0, 0, 1, 0, 0, 0, 0,  0,       1, 3,  'hBAD,    0, 1, 1, 7,       1,      1,      4, 1, 0, 0};
`endif

        rst = 1'b1; hold = 1'b0; flush = 1'b0; id_valid = 1'b1;
        id_alu_ctrl = 4'd0; id_rs_addr = 5'd1; id_rt_addr = 5'd2; id_rd_addr = 5'd3;
        id_rs_data = 32'h11; id_rt_data = 32'h22; id_imm = 32'd0; id_shamt = 5'd0;
        id_use_imm = 1'b0; id_use_shamt = 1'b0; id_reg_write = 1'b1;
        id_mem_read = 1'b0; id_mem_write = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) run(main_tbl[i], "main", i);

        // Load-use killed by flush, then reset arriving mid-stall.
        for (int i = 0; i < 4; i++) run(lu_tbl[i], "loaduse", i);
        chk("loaduse.stall_after_rst", 32'(stall), 32'd0);

        for (int i = 0; i < $size(raw_tbl); i++) run(raw_tbl[i], "raw", i);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
